// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift-register command sequencer.
//   N          : shift register width
//   ADDRWIDTH  : width of the opaque command tag
//   OPW        : width of the register mode select
//   AMTW       : width of the shift-amount field (0..N representable)
//   shift_op_e : register mode-select encoding
//   seq_state_e: sequencer FSM states
//   eff_amount : clamps a requested amount to N, zero for non-shifting ops
package shift_sequencer_pkg;

  localparam int N         = 8;
  localparam int ADDRWIDTH = 8;
  localparam int OPW       = $clog2(N);
  localparam int AMTW      = $clog2(N) + 1;

  typedef enum logic [OPW-1:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ASR  = 3'd6,
    OP_SLL0 = 3'd7
  } shift_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } seq_state_e;

  // HOLD and LOAD never shift, so they get no shift cycles at all.
  function automatic logic [AMTW-1:0] eff_amount(input shift_op_e op,
                                                 input logic [AMTW-1:0] amt);
    if (op == OP_HOLD || op == OP_LOAD) return '0;
    else if (amt > AMTW'(N))            return AMTW'(N);
    else                                return amt;
  endfunction

endpackage

// File: rtl/shift_sequencer_amt_counter.sv
// shift_amt_counter: loadable down-counter for the number of shift cycles.
//   Clock, Clear : clock and asynchronous active-low clear
//   load/load_val: synchronous load (has priority over decrement)
//   dec          : decrement by one, saturating at zero
//   cnt          : current count
//   last         : cnt == 1, i.e. the current cycle is the final shift
module shift_amt_counter
  import shift_sequencer_pkg::*;
#(
  parameter int W = AMTW
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for an N-bit mode-select
// shift register. One command at a time: optional parallel load, then
// eff_amt shift cycles, then the register output is captured and returned.
//
// Handshakes: a transfer happens on a rising Clock edge where valid and
// ready are both 1. Once valid is raised, the producer holds it and the
// payload stable until the transfer. cmd_ready is 1 only in IDLE; rsp_valid
// is 1 only in RESP, and rsp_data/rsp_tag are stable throughout RESP.
//
// Ports:
//   Clock, Clear           : clock, asynchronous active-low clear
//   cmd_*                  : command channel (valid/ready + payload)
//   sr_S, sr_D             : mode select and parallel data to the register
//   sr_MSBIn, sr_LSBIn     : serial inputs to the register
//   sr_Q                   : register output
//   rsp_*                  : response channel (valid/ready + data, tag)
//   busy                   : sequencer not in IDLE
//   dbg_state              : current FSM state, for observation
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int N         = shift_sequencer_pkg::N,
  parameter int ADDRWIDTH = shift_sequencer_pkg::ADDRWIDTH,
  parameter int AMTW      = $clog2(N) + 1
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [$clog2(N)-1:0] cmd_op,
  input  logic [AMTW-1:0]      cmd_amt,
  input  logic                 cmd_load,
  input  logic [N-1:0]         cmd_data,
  input  logic                 cmd_sin,
  input  logic [ADDRWIDTH-1:0] cmd_tag,
  output logic [$clog2(N)-1:0] sr_S,
  output logic [N-1:0]         sr_D,
  output logic                 sr_MSBIn,
  output logic                 sr_LSBIn,
  input  logic [N-1:0]         sr_Q,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_data,
  output logic [ADDRWIDTH-1:0] rsp_tag,
  output logic                 busy,
  output seq_state_e           dbg_state
);

  seq_state_e             state_q, state_d;
  shift_op_e              op_q;
  logic [N-1:0]           data_q;
  logic                   sin_q;
  logic [ADDRWIDTH-1:0]   tag_q;
  logic [AMTW-1:0]        amt_q;
  logic [AMTW-1:0]        eff_in;
  logic                   accept, capture;
  logic                   cnt_load, cnt_last;
  logic [AMTW-1:0]        cnt_val, cnt;

  assign eff_in    = eff_amount(shift_op_e'(cmd_op), cmd_amt);
  assign sr_D      = data_q;
  assign dbg_state = state_q;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    sr_S      = OP_HOLD;
    sr_MSBIn  = 1'b0;
    sr_LSBIn  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = amt_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_load) begin
            state_d = ST_LOAD;
          end else if (eff_in != '0) begin
            state_d  = ST_SHIFT;
            cnt_load = 1'b1;
            cnt_val  = eff_in;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_LOAD: begin
        sr_S = OP_LOAD;
        if (amt_q != '0) begin
          state_d  = ST_SHIFT;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_SHIFT: begin
        sr_S     = op_q;
        sr_MSBIn = (op_q == OP_SHR) ? sin_q : 1'b0;
        sr_LSBIn = (op_q == OP_SHL) ? sin_q : 1'b0;
        // Leaving on cnt==1 gives exactly eff_amt cycles with sr_S=op.
        if (cnt_last) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  shift_amt_counter #(.W(AMTW)) u_cnt (
    .Clock    (Clock),
    .Clear    (Clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (state_q == ST_SHIFT),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      op_q     <= OP_HOLD;
      data_q   <= '0;
      sin_q    <= 1'b0;
      tag_q    <= '0;
      amt_q    <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
    end else begin
      if (accept) begin
        op_q   <= shift_op_e'(cmd_op);
        data_q <= cmd_data;
        sin_q  <= cmd_sin;
        tag_q  <= cmd_tag;
        amt_q  <= eff_in;
      end
      if (capture) begin
        rsp_data <= sr_Q;
        rsp_tag  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Clear = 1'b0;
  always #5 Clock = ~Clock;

  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [OPW-1:0]       cmd_op = '0;
  logic [AMTW-1:0]      cmd_amt = '0;
  logic                 cmd_load = 1'b0;
  logic [N-1:0]         cmd_data = '0;
  logic                 cmd_sin = 1'b0;
  logic [ADDRWIDTH-1:0] cmd_tag = '0;
  logic [OPW-1:0]       sr_S;
  logic [N-1:0]         sr_D;
  logic                 sr_MSBIn, sr_LSBIn;
  logic [N-1:0]         sr_Q;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [N-1:0]         rsp_data;
  logic [ADDRWIDTH-1:0] rsp_tag;
  logic                 busy;
  seq_state_e           dbg_state;

  shift_sequencer dut (
    .Clock(Clock), .Clear(Clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_amt(cmd_amt), .cmd_load(cmd_load), .cmd_data(cmd_data),
    .cmd_sin(cmd_sin), .cmd_tag(cmd_tag),
    .sr_S(sr_S), .sr_D(sr_D), .sr_MSBIn(sr_MSBIn), .sr_LSBIn(sr_LSBIn),
    .sr_Q(sr_Q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .busy(busy), .dbg_state(dbg_state)
  );

  // The controlled shift register, sitting beside the sequencer.
  logic [N-1:0] sr_reg;
  assign sr_Q = sr_reg;
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) sr_reg <= '0;
    else case (sr_S)
      3'd1: sr_reg <= sr_D;
      3'd2: sr_reg <= {sr_MSBIn, sr_reg[N-1:1]};
      3'd3: sr_reg <= {sr_reg[N-2:0], sr_LSBIn};
      3'd4: sr_reg <= {sr_reg[0], sr_reg[N-1:1]};
      3'd5: sr_reg <= {sr_reg[N-2:0], sr_reg[N-1]};
      3'd6: sr_reg <= {sr_reg[N-1], sr_reg[N-1:1]};
      3'd7: sr_reg <= {sr_reg[N-2:0], 1'b0};
      default: sr_reg <= sr_reg;
    endcase
  end

  // ---------------- scoreboard ----------------
  localparam int W = ADDRWIDTH + N;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int shadow = 0;        // expected register contents between commands
  int exp_lat = 0;
  int trace[$];          // sr_S seen after accept and after each later edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Command-level reference: plain arithmetic on an integer value.
  function automatic int eff_of(input int op, input int amt);
    if (op < 2) return 0;
    return (amt > N) ? N : amt;
  endfunction

  function automatic int ref_result(input int start, input int op, input int amt, input int sin);
    int v = start;
    for (int i = 0; i < eff_of(op, amt); i++) begin
      case (op)
        2: v = (v >> 1) | (sin * 128);
        3: v = ((v << 1) & 255) | sin;
        4: v = (v >> 1) | ((v & 1) << 7);
        5: v = ((v << 1) & 255) | (v >> 7);
        6: v = (v >> 1) | (v & 128);
        7: v = (v << 1) & 255;
        default: v = v;
      endcase
    end
    return v;
  endfunction

  // Compute, record and push the expected response of the presented command.
  task automatic expect_cmd();
    int start, res;
    start = cmd_load ? int'(cmd_data) : shadow;
    res = ref_result(start, int'(cmd_op), int'(cmd_amt), int'(cmd_sin));
    shadow = res;
    exp_lat = eff_of(int'(cmd_op), int'(cmd_amt)) + 1 + int'(cmd_load);
    exp_q.push_back({cmd_tag, res[N-1:0]});
  endtask

  // Monitor: compare every completed response against the queue head.
  always @(negedge Clock) begin
    if (Clear && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e[N-1:0]));
        check("rsp_tag", 32'(rsp_tag), 32'(e[W-1:N]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present(input int op, input int amt, input int load,
                         input int data, input int sin, input int tag);
    cmd_op = OPW'(op); cmd_amt = AMTW'(amt); cmd_load = load[0];
    cmd_data = N'(data); cmd_sin = sin[0]; cmd_tag = ADDRWIDTH'(tag);
    cmd_valid = 1'b1;
  endtask

  task automatic issue(input int op, input int amt, input int load,
                       input int data, input int sin, input int tag);
    int k = 0;
    @(negedge Clock);
    present(op, amt, load, data, sin, tag);
    while (!cmd_ready && k < 50) begin @(negedge Clock); k++; end
    if (k >= 50) check("cmd_accept_timeout", 32'd1, 32'd0);
    expect_cmd();
    @(posedge Clock); #1;
    cmd_valid = 1'b0;
    trace.delete();
    trace.push_back(int'(sr_S));
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (k < 40) begin
      @(posedge Clock); #1; k++;
      trace.push_back(int'(sr_S));
      if (rsp_valid) break;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd1, 32'd0);
    check("latency", 32'(k), 32'(exp_lat));
  endtask

  task automatic run_cmd(input int op, input int amt, input int load,
                         input int data, input int sin, input int tag);
    issue(op, amt, load, data, sin, tag);
    wait_rsp();
    @(posedge Clock); #1;
  endtask

  task automatic test_ror();
    run_cmd(4, 3, 1, 'hA5, 0, 5);
    check("trace_len", 32'(trace.size() >= 5), 32'd1);
    if (trace.size() >= 5) begin
      check("sr_S_0", 32'(trace[0]), 32'd1);
      check("sr_S_1", 32'(trace[1]), 32'd4);
      check("sr_S_2", 32'(trace[2]), 32'd4);
      check("sr_S_3", 32'(trace[3]), 32'd4);
      check("sr_S_4", 32'(trace[4]), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] exp_a;
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_sr_S", 32'(sr_S), 32'd0);
    check("rst_sr_D", 32'(sr_D), 32'd0);
    check("rst_msb_lsb", 32'({sr_MSBIn, sr_LSBIn}), 32'd0);
    @(negedge Clock); Clear = 1'b1;

    test_ror();
    run_cmd(2, 4, 1, 'h00, 1, 1);   // F0
    run_cmd(3, 2, 0, 'h00, 0, 2);   // C0, latency 3
    run_cmd(6, 2, 1, 'h90, 0, 3);   // E4
    run_cmd(7, 1, 1, 'h81, 0, 4);   // 02
    run_cmd(5, 12, 1, 'h3C, 0, 6);  // clamp to 8, 3C, latency 10
    run_cmd(4, 0, 1, 'h5A, 0, 7);   // amt 0 with load, latency 2
    run_cmd(0, 5, 0, 'hFF, 1, 8);   // HOLD, current Q, latency 1

    // Back-pressure: response held, next command must wait.
    rsp_ready = 1'b0;
    issue(4, 2, 1, 'h0F, 0, 9);
    wait_rsp();
    exp_a = exp_q[0];
    @(negedge Clock);
    present(3, 3, 0, 0, 1, 10);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_stable", 32'({rsp_tag, rsp_data}), 32'(exp_a));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_state", 32'(dbg_state), 32'(ST_RESP));
    end
    @(posedge Clock); #1; rsp_ready = 1'b1;
    @(negedge Clock);                       // monitor takes A here
    @(negedge Clock);
    check("bp_ready_after", 32'(cmd_ready), 32'd1);
    expect_cmd();
    @(posedge Clock); #1;
    check("bp_accept", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    wait_rsp();
    @(posedge Clock); #1;

    // Clear in the middle of SHIFT (cnt==3 after six edges).
    issue(4, 8, 1, 'h77, 0, 11);
    repeat (6) @(posedge Clock);
    @(negedge Clock); Clear = 1'b0; #1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_sr_S", 32'(sr_S), 32'd0);
    check("clr_rsp_valid", 32'(rsp_valid), 32'd0);
    void'(exp_q.pop_back());
    shadow = 0;
    @(negedge Clock); Clear = 1'b1;
    repeat (4) @(negedge Clock);
    check("clr_no_rsp", 32'(rsp_valid), 32'd0);
    test_ror();

    // Randomized commands.
    for (int i = 0; i < 30; i++)
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));

    repeat (3) @(negedge Clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
